// File: rtl/apb_timer_if.sv
// APB bus bundle for the timer slave.
// Signals: PSEL, PENABLE, PWRITE, PADDR[31:0] and PWDATA[31:0] travel from
// master to slave. PRDATA[31:0] and PREADY travel from slave to master.
// The master modport drives the request side and the slave modport drives
// the response side.
interface apb_timer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_timer.sv
// 32-bit APB timer. It has a programmable prescaler, a compare match with a
// sticky MATCH status bit, and a level interrupt.
// Ports:
//   clk - system clock. All state updates on the rising edge.
//   rst - asynchronous, active-high reset.
//   apb - APB slave port: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY.
//         Only PADDR[4:2] is decoded. Writes have zero wait states.
//         Reads insert one wait state.
//   irq - level interrupt, equal to STATUS.MATCH & CTRL.IRQ_EN.
// Register map (PADDR[4:2]):
//   0 CTRL     - bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN
//   1 PRESCALE - [PRESCALE_W-1:0]
//   2 COMPARE  - [31:0]
//   3 COUNT    - [31:0]
//   4 STATUS   - bit0 MATCH, write 1 to clear
//   5-7        - read as zero, writes ignored
module apb_timer #(
    parameter int          PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic       clk,
    input  logic       rst,
    apb_timer_if.slave apb,
    output logic       irq
);
    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_COMPARE  = 3'd2;
    localparam logic [2:0] ADDR_COUNT    = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;

    logic                  en_reg, en_next;
    logic                  auto_reload_reg, auto_reload_next;
    logic                  irq_en_reg, irq_en_next;
    logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
    logic [PRESCALE_W-1:0] presc_cnt_reg, presc_cnt_next;
    logic [31:0]           compare_reg, compare_next;
    logic [31:0]           count_reg, count_next;
    logic                  match_reg, match_next;
    logic [31:0]           prdata_reg, prdata_next;
    logic                  rd_pend_reg, rd_pend_next;

    logic [2:0]  addr;
    logic        access;
    logic        wr_en;
    logic        rd_first;
    logic        tick;
    logic        hit;
    logic        wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
    logic [31:0] rdata;
    logic        unused_paddr;

    assign addr         = apb.PADDR[4:2];
    assign unused_paddr = ^{apb.PADDR[31:5], apb.PADDR[1:0]};

    assign access   = apb.PSEL & apb.PENABLE;
    assign wr_en    = access & apb.PWRITE;
    // A read is sampled only in its first access cycle. The following
    // cycle completes it.
    assign rd_first = access & ~apb.PWRITE & ~rd_pend_reg;

    assign wr_ctrl     = wr_en & (addr == ADDR_CTRL);
    assign wr_prescale = wr_en & (addr == ADDR_PRESCALE);
    assign wr_compare  = wr_en & (addr == ADDR_COMPARE);
    assign wr_count    = wr_en & (addr == ADDR_COUNT);
    assign wr_status   = wr_en & (addr == ADDR_STATUS);

    assign tick = en_reg & (presc_cnt_reg == prescale_reg);
    assign hit  = tick & (count_reg == compare_reg);

    // Read mux. It is sampled into prdata_reg, so nothing here reaches PRDATA
    // combinationally.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_CTRL:     rdata = {29'd0, irq_en_reg, auto_reload_reg, en_reg};
            ADDR_PRESCALE: rdata = 32'(prescale_reg);
            ADDR_COMPARE:  rdata = compare_reg;
            ADDR_COUNT:    rdata = count_reg;
            ADDR_STATUS:   rdata = {31'd0, match_reg};
            default:       rdata = 32'd0;
        endcase
    end

    always_comb begin
        en_next          = en_reg;
        auto_reload_next = auto_reload_reg;
        irq_en_next      = irq_en_reg;
        prescale_next    = prescale_reg;
        presc_cnt_next   = presc_cnt_reg;
        compare_next     = compare_reg;
        count_next       = count_reg;
        match_next       = match_reg;
        prdata_next      = prdata_reg;
        rd_pend_next     = rd_first;

        if (rd_first) begin
            prdata_next = rdata;
        end

        // A COUNT write restarts the prescale period so the written value
        // lasts a full period.
        if (wr_count) begin
            presc_cnt_next = '0;
        end else if (en_reg) begin
            presc_cnt_next = tick ? '0 : presc_cnt_reg + 1'b1;
        end

        // A written COUNT overrides the tick update in the same cycle.
        if (wr_count) begin
            count_next = apb.PWDATA;
        end else if (hit) begin
            if (auto_reload_reg) begin
                count_next = 32'd0;
            end
        end else if (tick) begin
            count_next = count_reg + 32'd1;
        end

        // A match set takes priority over a write-1-to-clear in the same cycle.
        if (hit) begin
            match_next = 1'b1;
        end else if (wr_status && apb.PWDATA[0]) begin
            match_next = 1'b0;
        end

        // A CTRL write wins over the one-shot auto-clear of EN.
        if (wr_ctrl) begin
            en_next          = apb.PWDATA[0];
            auto_reload_next = apb.PWDATA[1];
            irq_en_next      = apb.PWDATA[2];
        end else if (hit && !auto_reload_reg) begin
            en_next = 1'b0;
        end

        if (wr_prescale) begin
            prescale_next = apb.PWDATA[PRESCALE_W-1:0];
        end
        if (wr_compare) begin
            compare_next = apb.PWDATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg          <= 1'b0;
            auto_reload_reg <= 1'b0;
            irq_en_reg      <= 1'b0;
            prescale_reg    <= '0;
            presc_cnt_reg   <= '0;
            compare_reg     <= COMPARE_RST;
            count_reg       <= 32'd0;
            match_reg       <= 1'b0;
            prdata_reg      <= 32'd0;
            rd_pend_reg     <= 1'b0;
        end else begin
            en_reg          <= en_next;
            auto_reload_reg <= auto_reload_next;
            irq_en_reg      <= irq_en_next;
            prescale_reg    <= prescale_next;
            presc_cnt_reg   <= presc_cnt_next;
            compare_reg     <= compare_next;
            count_reg       <= count_next;
            match_reg       <= match_next;
            prdata_reg      <= prdata_next;
            rd_pend_reg     <= rd_pend_next;
        end
    end

    // PREADY is held low while reset is asserted, so an aborted transfer
    // never completes.
    assign apb.PREADY = ~rst & (wr_en | (access & ~apb.PWRITE & rd_pend_reg));
    assign apb.PRDATA = prdata_reg;
    assign irq        = match_reg & irq_en_reg;
endmodule

// File: doc/apb_timer.md
Name: apb_timer

Overview:
- 32-bit APB slave timer: prescaler, compare match, sticky match status and a level interrupt.
- Sits directly downstream of the core's APB master, on the shared PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY bus inside the 0x4000_xxxx peripheral window.
- Gives the RISC-V core a polled or interrupt-driven time base.
- Reads insert one wait state, which exercises the master's PREADY stall path.

Parameters:
- PRESCALE_W, 16: width of the PRESCALE register, in bits.
- COMPARE_RST, 32'hFFFF_FFFF: reset value of the COMPARE register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- PSEL  input  1  slave select from the APB master.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  32  byte address; only PADDR[4:2] is decoded.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer complete.
- irq  output  1  level interrupt, equal to STATUS.MATCH & CTRL.IRQ_EN.

Behaviour:
- Reset: the clock is clk; reset is rst, asynchronous and active-high.
  - PRDATA=0, PREADY=0, irq=0.
  - CTRL=0, PRESCALE=0, COMPARE=COMPARE_RST, COUNT=0, STATUS=0.
  - Prescaler counter=0, read-pending flag=0.
  - Reset asserted mid-transfer aborts the transfer; no register write commits.
- Register map, selected by PADDR[4:2]:
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 1 PRESCALE: [PRESCALE_W-1:0].
  - 2 COMPARE: [31:0].
  - 3 COUNT: [31:0], read/write.
  - 4 STATUS: bit0 MATCH; write 1 to clear, write 0 has no effect.
  - 5-7: read 0, writes ignored.
- Write handshake:
  - In any PSEL&PENABLE&PWRITE cycle, PREADY=1 combinationally (zero wait states).
  - The register updates on that clock edge.
- Read handshake:
  - First PSEL&PENABLE&!PWRITE cycle: PREADY=0; the addressed value is sampled into PRDATA at the edge and the pending flag is set.
  - Next cycle: PREADY=1, PRDATA stable; the pending flag clears at that edge.
  - PRDATA holds its last value otherwise.
  - PREADY=0 whenever PSEL&PENABLE is not true.
  - If PSEL drops while a read is pending, the pending flag clears.
- Prescaler:
  - While EN=1, the prescaler increments each clk.
  - When it equals PRESCALE it wraps to 0 and generates a one-cycle tick.
  - PRESCALE=0 therefore ticks every cycle.
  - EN=0 holds both the prescaler and COUNT.
- Count on tick:
  - If COUNT==COMPARE:
    - STATUS.MATCH<=1.
    - If AUTO_RELOAD=1, COUNT<=0 and counting continues.
    - If AUTO_RELOAD=0, COUNT holds and EN<=0 (one-shot).
  - Otherwise COUNT<=COUNT+1, wrapping 0xFFFF_FFFF to 0 with no flag.
- Simultaneous-event priorities:
  - Write to COUNT in the same cycle as a tick: the written value wins; the prescaler is also cleared to 0.
  - STATUS W1C in the same cycle as a match: set wins, MATCH stays 1.
  - CTRL write in the same cycle as a one-shot auto-clear of EN: the written value wins.
- irq is a registered-state function (MATCH & IRQ_EN) and carries no combinational path from the APB inputs.

Test Plan:
- Reset, then read all 8 offsets -> each read takes PREADY low 1 cycle then high. Values: CTRL=0, PRESCALE=0, COMPARE=0xFFFF_FFFF, COUNT=0, STATUS=0, offsets 5-7 = 0. irq=0.
- Write PRESCALE=3, COMPARE=5, CTRL=0x7 (EN, AUTO_RELOAD, IRQ_EN) -> MATCH and irq rise 24 cycles after the CTRL write. COUNT returns to 0 and rolls again every 24 cycles.
- Write CTRL=0x1 (one-shot), PRESCALE=0, COMPARE=2 -> after 3 ticks MATCH=1, COUNT reads 2, CTRL reads 0. COUNT stays 2 thereafter.
- With MATCH=1, write STATUS=1 -> MATCH=0, irq falls. Repeat the write in the exact cycle of a new match -> MATCH stays 1.
- Write COUNT=0x1234 while counting with PRESCALE=0 -> next read returns 0x1234 plus elapsed ticks; the written value is not lost to a same-cycle increment.
- Write COUNT=0xFFFF_FFFF, COMPARE=0x10, EN=1, PRESCALE=0 -> COUNT wraps to 0 with no MATCH, then MATCH is set when COUNT reaches 0x10. Assert rst mid-read -> PREADY=0 and all registers return to reset values.
